// File: rtl/duc_retune_sequencer.sv
// duc_retune_sequencer
// Sequences a retune of one digital up-conversion chain over the settings bus.
// A rate change gates run, drains the pipeline, writes the three chain registers
// and lets the filters settle before releasing run. A request that only changes
// frequency or gain writes phase and scale without touching run.

module duc_retune_sequencer #(
   parameter logic [7:0] BASE          = 8'd0,
   parameter int         DRAIN_CYCLES  = 512,
   parameter int         SETTLE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_phase_inc,
   input  logic [17:0] req_scale,
   input  logic [7:0]  req_interp,
   input  logic        req_hb1,
   input  logic        req_hb2,
   input  logic        run_in,
   output logic        run_out,
   output logic        set_stb,
   output logic [7:0]  set_addr,
   output logic [31:0] set_data,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] DRAIN  = 3'd1;
   localparam logic [2:0] WR_PH  = 3'd2;
   localparam logic [2:0] WR_SC  = 3'd3;
   localparam logic [2:0] WR_RT  = 3'd4;
   localparam logic [2:0] SETTLE = 3'd5;

   logic [2:0]  state;
   logic [15:0] cnt;
   logic        full_path;
   logic [31:0] cap_phase;
   logic [17:0] cap_scale;
   logic [9:0]  cap_rate;
   logic [9:0]  shadow_rate;
   logic        shadow_valid;

   logic        accept;
   logic [9:0]  req_rate;
   logic        rate_match;

   // The done cycle is still IDLE but must not accept, so a held request
   // lands one cycle later.
   assign req_ready  = (state == IDLE) && !done;
   assign accept     = req_valid && req_ready;
   assign req_rate   = {req_hb1, req_hb2, req_interp};
   assign rate_match = shadow_valid && (req_rate == shadow_rate);
   assign busy       = (state != IDLE);

   // Main sequencer: state walk, request capture, run gating and completion pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= 16'd0;
         full_path    <= 1'b0;
         cap_phase    <= 32'd0;
         cap_scale    <= 18'd0;
         cap_rate     <= 10'd0;
         shadow_rate  <= 10'd0;
         shadow_valid <= 1'b0;
         run_out      <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               run_out <= run_in;
               if (accept) begin
                  if (req_interp == 8'd0) begin
                     err <= 1'b1;
                  end else begin
                     cap_phase <= req_phase_inc;
                     cap_scale <= req_scale;
                     cap_rate  <= req_rate;
                     if (rate_match) begin
                        full_path <= 1'b0;
                        state     <= WR_PH;
                     end else begin
                        full_path <= 1'b1;
                        state     <= DRAIN;
                        cnt       <= 16'(DRAIN_CYCLES - 1);
                        run_out   <= 1'b0;
                     end
                  end
               end
            end
            DRAIN: begin
               run_out <= 1'b0;
               if (cnt == 16'd0) begin
                  state <= WR_PH;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            WR_PH: begin
               run_out <= full_path ? 1'b0 : run_in;
               state   <= WR_SC;
            end
            WR_SC: begin
               if (full_path) begin
                  run_out <= 1'b0;
                  state   <= WR_RT;
               end else begin
                  run_out     <= run_in;
                  shadow_rate <= cap_rate;
                  done        <= 1'b1;
                  state       <= IDLE;
               end
            end
            WR_RT: begin
               run_out      <= 1'b0;
               shadow_rate  <= cap_rate;
               shadow_valid <= 1'b1;
               cnt          <= 16'(SETTLE_CYCLES - 1);
               state        <= SETTLE;
            end
            SETTLE: begin
               if (cnt == 16'd0) begin
                  run_out <= run_in;
                  done    <= 1'b1;
                  state   <= IDLE;
               end else begin
                  run_out <= 1'b0;
                  cnt     <= cnt - 16'd1;
               end
            end
            default: begin
               run_out <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

   // Settings bus is decoded from the write states; address and data stay zero otherwise.
   always_comb begin
      set_stb  = 1'b0;
      set_addr = 8'd0;
      set_data = 32'd0;
      case (state)
         WR_PH: begin
            set_stb  = 1'b1;
            set_addr = BASE;
            set_data = cap_phase;
         end
         WR_SC: begin
            set_stb  = 1'b1;
            set_addr = BASE + 8'd1;
            set_data = {14'd0, cap_scale};
         end
         WR_RT: begin
            set_stb  = 1'b1;
            set_addr = BASE + 8'd2;
            set_data = {22'd0, cap_rate};
         end
         default: begin
            set_stb  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_duc_retune_sequencer.sv
// tb_duc_retune_sequencer
// Directed bench for the retune sequencer: a per-cycle vector table covering a
// full path, a fast path, a rejected request and a second full path, followed by
// hand-written sequences for reset during drain, run_in dropping in settle and a
// request held valid across completions.

module tb_duc_retune_sequencer;

   localparam logic [7:0] TB_BASE   = 8'h40;
   localparam int         TB_DRAIN  = 8;
   localparam int         TB_SETTLE = 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_phase_inc;
   logic [17:0] req_scale;
   logic [7:0]  req_interp;
   logic        req_hb1;
   logic        req_hb2;
   logic        run_in;
   logic        run_out;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic        busy;
   logic        done;
   logic        err;

   int total_checks = 0;
   int passed_checks = 0;

   typedef struct {
      logic        valid;
      logic        run;
      logic [31:0] phase;
      logic [17:0] scale;
      logic [7:0]  interp;
      logic        hb1;
      logic        hb2;
      logic        e_ready;
      logic        e_busy;
      logic        e_run;
      logic        e_stb;
      logic [7:0]  e_addr;
      logic [31:0] e_data;
      logic        e_done;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   duc_retune_sequencer #(
      .BASE          (TB_BASE),
      .DRAIN_CYCLES  (TB_DRAIN),
      .SETTLE_CYCLES (TB_SETTLE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_phase_inc (req_phase_inc),
      .req_scale     (req_scale),
      .req_interp    (req_interp),
      .req_hb1       (req_hb1),
      .req_hb2       (req_hb2),
      .run_in        (run_in),
      .run_out       (run_out),
      .set_stb       (set_stb),
      .set_addr      (set_addr),
      .set_data      (set_data),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void addVec(input logic v, input logic r, input logic [31:0] ph,
                                  input logic [17:0] sc, input logic [7:0] it,
                                  input logic h1, input logic h2,
                                  input logic rdy, input logic bsy, input logic ro,
                                  input logic stb, input logic [7:0] ad,
                                  input logic [31:0] da, input logic dn, input logic er);
      vec_t x;
      x.valid = v;  x.run = r;  x.phase = ph;  x.scale = sc;  x.interp = it;
      x.hb1 = h1;  x.hb2 = h2;
      x.e_ready = rdy;  x.e_busy = bsy;  x.e_run = ro;  x.e_stb = stb;
      x.e_addr = ad;  x.e_data = da;  x.e_done = dn;  x.e_err = er;
      vecs.push_back(x);
   endfunction

   task automatic applyStimulus(input logic v, input logic r, input logic [31:0] ph,
                                input logic [17:0] sc, input logic [7:0] it,
                                input logic h1, input logic h2);
      req_valid     = v;
      run_in        = r;
      req_phase_inc = ph;
      req_scale     = sc;
      req_interp    = it;
      req_hb1       = h1;
      req_hb2       = h2;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act === exp) begin
         passed_checks++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic rdy, input logic bsy, input logic ro,
                           input logic stb, input logic [7:0] ad, input logic [31:0] da,
                           input logic dn, input logic er);
      checkOutput({tag, ".req_ready"}, {31'd0, req_ready}, {31'd0, rdy});
      checkOutput({tag, ".busy"},      {31'd0, busy},      {31'd0, bsy});
      checkOutput({tag, ".run_out"},   {31'd0, run_out},   {31'd0, ro});
      checkOutput({tag, ".set_stb"},   {31'd0, set_stb},   {31'd0, stb});
      checkOutput({tag, ".set_addr"},  {24'd0, set_addr},  {24'd0, ad});
      checkOutput({tag, ".set_data"},  set_data,           da);
      checkOutput({tag, ".done"},      {31'd0, done},      {31'd0, dn});
      checkOutput({tag, ".err"},       {31'd0, err},       {31'd0, er});
   endtask

   // Directed test sequence.
   initial begin
      logic [31:0] exp_data;
      logic [7:0]  exp_addr;
      logic        exp_stb;
      logic        exp_run;
      logic        drive_run;

      // Full path: phase 0x01000000, scale 0x0A000, interp 4, both halfbands.
      addVec(1, 1, 32'h0100_0000, 18'h0A000, 8'd4, 1, 1,  1, 0, 1, 0, 8'd0, 32'd0, 0, 0);
      for (int i = 0; i < TB_DRAIN; i++)
         addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 0, 8'd0, 32'd0, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 1, TB_BASE,        32'h0100_0000, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 1, TB_BASE + 8'd1, 32'h0000_A000, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 1, TB_BASE + 8'd2, 32'h0000_0304, 0, 0);
      for (int i = 0; i < TB_SETTLE; i++)
         addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 0, 8'd0, 32'd0, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 0, 1, 0, 8'd0, 32'd0, 1, 0);
      // Fast path: new phase, same rate and enables.
      addVec(1, 1, 32'h0200_0000, 18'h0A000, 8'd4, 1, 1,  1, 0, 1, 0, 8'd0, 32'd0, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 1, 1, TB_BASE,        32'h0200_0000, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 1, 1, TB_BASE + 8'd1, 32'h0000_A000, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 0, 1, 0, 8'd0, 32'd0, 1, 0);
      // Rejected request with interp 0.
      addVec(1, 1, 32'h0500_0000, 18'h00001, 8'd0, 1, 1,  1, 0, 1, 0, 8'd0, 32'd0, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  1, 0, 1, 0, 8'd0, 32'd0, 0, 1);
      // Next valid request with a new rate takes the full path.
      addVec(1, 1, 32'h0300_0000, 18'h00123, 8'd8, 0, 1,  1, 0, 1, 0, 8'd0, 32'd0, 0, 0);
      for (int i = 0; i < TB_DRAIN; i++)
         addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 0, 8'd0, 32'd0, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 1, TB_BASE,        32'h0300_0000, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 1, TB_BASE + 8'd1, 32'h0000_0123, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 1, TB_BASE + 8'd2, 32'h0000_0108, 0, 0);
      for (int i = 0; i < TB_SETTLE; i++)
         addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 1, 0, 0, 8'd0, 32'd0, 0, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  0, 0, 1, 0, 8'd0, 32'd0, 1, 0);
      addVec(0, 1, 32'd0, 18'd0, 8'd0, 0, 0,  1, 0, 1, 0, 8'd0, 32'd0, 0, 0);

      // Reset state.
      rst_n = 1'b0;
      applyStimulus(0, 1, 32'd0, 18'd0, 8'd0, 0, 0);
      @(negedge clk);
      checkAll("reset", 1, 0, 0, 0, 8'd0, 32'd0, 0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         checkAll($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_run,
                  vecs[i].e_stb, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_done, vecs[i].e_err);
         applyStimulus(vecs[i].valid, vecs[i].run, vecs[i].phase, vecs[i].scale,
                       vecs[i].interp, vecs[i].hb1, vecs[i].hb2);
      end

      // Reset during DRAIN aborts with no writes.
      @(negedge clk);
      applyStimulus(1, 1, 32'h0700_0000, 18'h00777, 8'd16, 0, 1);
      @(negedge clk);
      checkOutput("rstdrain.busy_t1", {31'd0, busy}, 32'd1);
      applyStimulus(0, 1, 32'd0, 18'd0, 8'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkAll("rstdrain.async", 1, 0, 0, 0, 8'd0, 32'd0, 0, 0);
      @(negedge clk);
      checkOutput("rstdrain.stb_held", {31'd0, set_stb}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstdrain.idle_run", {31'd0, run_out}, 32'd1);
      // Rate 0x108 matched the shadow before reset; it must now take the full path.
      applyStimulus(1, 1, 32'h0900_0000, 18'h00999, 8'd8, 0, 1);

      // Full path with run_in dropped in SETTLE and raised two cycles after done.
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         exp_stb  = (k >= 9) && (k <= 11);
         exp_addr = 8'd0;
         exp_data = 32'd0;
         if (k == 9)  begin exp_addr = TB_BASE;        exp_data = 32'h0900_0000; end
         if (k == 10) begin exp_addr = TB_BASE + 8'd1; exp_data = 32'h0000_0999; end
         if (k == 11) begin exp_addr = TB_BASE + 8'd2; exp_data = 32'h0000_0108; end
         exp_run = (k >= 19);
         checkAll($sformatf("settle_drop.k%0d", k), (k >= 17), (k <= 15), exp_run,
                  exp_stb, exp_addr, exp_data, (k == 16), 0);
         drive_run = !((k >= 13) && (k < 18));
         applyStimulus(0, drive_run, 32'd0, 18'd0, 8'd0, 0, 0);
      end

      // req_valid held high with fields changing every cycle; rate matches the shadow.
      for (int j = 0; j <= 8; j++) begin
         @(negedge clk);
         exp_stb  = (j == 1) || (j == 2) || (j == 5) || (j == 6);
         exp_addr = 8'd0;
         exp_data = 32'd0;
         if (j == 1) begin exp_addr = TB_BASE;        exp_data = 32'hA000_0000; end
         if (j == 2) begin exp_addr = TB_BASE + 8'd1; exp_data = 32'h0000_0100; end
         if (j == 5) begin exp_addr = TB_BASE;        exp_data = 32'hA000_0004; end
         if (j == 6) begin exp_addr = TB_BASE + 8'd1; exp_data = 32'h0000_0104; end
         checkAll($sformatf("held.j%0d", j), (j == 0) || (j == 4) || (j == 8),
                  (j == 1) || (j == 2) || (j == 5) || (j == 6), 1,
                  exp_stb, exp_addr, exp_data, (j == 3) || (j == 7), 0);
         applyStimulus(j < 8, 1, 32'hA000_0000 | 32'(j), 18'h00100 + 18'(j), 8'd8, 0, 1);
      end
      applyStimulus(0, 1, 32'd0, 18'd0, 8'd0, 0, 0);
      @(negedge clk);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
